// File: rtl/ulv_multi_shift_reg.sv
// Universal N-bit shift register with rotate/arithmetic/clear modes, multi-bit amounts
// and a start/busy/done handshake. Define USR_BARREL_EN for single-cycle barrel operation.
module ulv_multi_shift_reg #(
    parameter int N  = 8,
    parameter int AW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [2:0]    mode,
    input  logic [AW-1:0] amt,
    input  logic [N-1:0]  d,
    input  logic          sin_l,
    input  logic          sin_r,
    output logic [N-1:0]  q,
    output logic          so_l,
    output logic          so_r,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef enum logic [2:0] {
        M_HOLD = 3'b000, M_SHL  = 3'b001, M_SHR  = 3'b010, M_LOAD = 3'b011,
        M_ROTL = 3'b100, M_ROTR = 3'b101, M_ASHR = 3'b110, M_CLR  = 3'b111
    } mode_t;

    state_t         state_q;
    logic [N-1:0]   data_q;
    logic           so_l_q;
    logic           so_r_q;
    logic           busy_q;
    logic           done_q;
    logic [AW-1:0]  amt_sat;

    assign amt_sat = (amt > AW'(N)) ? AW'(N) : amt;

`ifdef USR_BARREL_EN
    // Extra guard bit at each end captures the last expelled bit (or keeps the old one when amt=0).
    logic [2*N:0]   left_w;
    logic [2*N:0]   right_w;
    logic [N-1:0]   fill_l;

    always_comb begin
        fill_l = (mode == M_ASHR) ? {N{data_q[N-1]}} : {N{sin_l}};
        if (mode == M_ROTL)
            left_w = {so_l_q, data_q, data_q} << amt_sat;
        else
            left_w = {so_l_q, data_q, {N{sin_r}}} << amt_sat;
        if (mode == M_ROTR)
            right_w = {data_q, data_q, so_r_q} >> amt_sat;
        else
            right_w = {fill_l, data_q, so_r_q} >> amt_sat;
    end
`else
    mode_t          mode_q;
    logic [AW-1:0]  cnt_q;
    logic [N-1:0]   step_d;

    always_comb begin
        step_d = data_q;
        case (mode_q)
            M_SHL:   step_d = {data_q[N-2:0], sin_r};
            M_SHR:   step_d = {sin_l, data_q[N-1:1]};
            M_ROTL:  step_d = {data_q[N-2:0], data_q[N-1]};
            M_ROTR:  step_d = {data_q[0], data_q[N-1:1]};
            M_ASHR:  step_d = {data_q[N-1], data_q[N-1:1]};
            default: step_d = data_q;
        endcase
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            so_l_q  <= 1'b0;
            so_r_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifndef USR_BARREL_EN
            mode_q  <= M_HOLD;
            cnt_q   <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        busy_q  <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= DONE;
`ifndef USR_BARREL_EN
                        mode_q  <= mode_t'(mode);
                        cnt_q   <= amt_sat;
`endif
                        case (mode_t'(mode))
                            M_HOLD: data_q <= data_q;
                            M_LOAD: data_q <= d;
                            M_CLR:  data_q <= '0;
`ifdef USR_BARREL_EN
                            M_SHL, M_ROTL: begin
                                data_q <= left_w[2*N-1:N];
                                so_l_q <= left_w[2*N];
                            end
                            default: begin
                                data_q <= right_w[N:1];
                                so_r_q <= right_w[0];
                            end
`else
                            default: begin
                                // A zero amount degenerates to a single-cycle no-op.
                                if (amt_sat != '0) begin
                                    done_q  <= 1'b0;
                                    state_q <= RUN;
                                end
                            end
`endif
                        endcase
                    end
                end
`ifndef USR_BARREL_EN
                RUN: begin
                    data_q <= step_d;
                    if (mode_q == M_SHL || mode_q == M_ROTL)
                        so_l_q <= data_q[N-1];
                    else
                        so_r_q <= data_q[0];
                    cnt_q <= cnt_q - AW'(1);
                    if (cnt_q == AW'(1)) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
`endif
                DONE: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign q    = data_q;
    assign so_l = so_l_q;
    assign so_r = so_r_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_ulv_multi_shift_reg.sv
// Randomised self-checking bench for ulv_multi_shift_reg against a transaction-level model.
// Follows USR_BARREL_EN so the same bench covers both builds.
module tb_ulv_multi_shift_reg;

    localparam int N  = 8;
    localparam int AW = $clog2(N + 1);

    localparam logic [2:0] HOLD = 3'd0, SHL = 3'd1, SHR = 3'd2, LOAD = 3'd3;
    localparam logic [2:0] ROTL = 3'd4, ROTR = 3'd5, ASHR = 3'd6, CLR = 3'd7;

    logic          clk;
    logic          reset;
    logic          start;
    logic [2:0]    mode;
    logic [AW-1:0] amt;
    logic [N-1:0]  d;
    logic          sin_l;
    logic          sin_r;
    logic [N-1:0]  q;
    logic          so_l;
    logic          so_r;
    logic          busy;
    logic          done;

    int numChecks = 0;
    int numErrors = 0;

    logic [N-1:0] modelQ;
    logic         modelSoL;
    logic         modelSoR;

    ulv_multi_shift_reg #(.N(N)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .amt(amt), .d(d),
        .sin_l(sin_l), .sin_r(sin_r), .q(q), .so_l(so_l), .so_r(so_r),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numErrors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Register value after i single-bit steps, expressed as bit-index arithmetic on the
    // starting value; bl/br hold the serial bits in the order they entered (index 1 first).
    function automatic logic [N-1:0] refShift(input logic [2:0] m, input logic [N-1:0] q0,
                                             input int i, input logic [N:0] bl, input logic [N:0] br);
        logic [N-1:0] r;
        r = q0;
        for (int p = 0; p < N; p++) begin
            case (m)
                SHL:  if (p >= i) r[p] = q0[p-i]; else r[p] = br[i-p];
                SHR:  if (p + i <= N - 1) r[p] = q0[p+i]; else r[p] = bl[p-N+1+i];
                ASHR: if (p + i <= N - 1) r[p] = q0[p+i]; else r[p] = q0[N-1];
                ROTL: r[p] = q0[(p - (i % N) + N) % N];
                ROTR: r[p] = q0[(p + i) % N];
                default: r[p] = q0[p];
            endcase
        end
        return r;
    endfunction

    task automatic checkAll(input string tag, input logic expBusy, input logic expDone);
        checkOutput({tag, ".q"},    32'(q),    32'(modelQ));
        checkOutput({tag, ".so_l"}, 32'(so_l), 32'(modelSoL));
        checkOutput({tag, ".so_r"}, 32'(so_r), 32'(modelSoR));
        checkOutput({tag, ".busy"}, 32'(busy), 32'(expBusy));
        checkOutput({tag, ".done"}, 32'(done), 32'(expDone));
    endtask

    task automatic driveGarbage(input bit garbage);
        if (garbage) begin
            start = 1'b1;
            mode  = LOAD;
            d     = '1;
            amt   = AW'($urandom_range(0, 15));
        end else begin
            start = 1'b0;
            d     = N'($urandom);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] m, input int a, input logic [N-1:0] data,
                                 input bit fixSin, input logic fl, input logic fr,
                                 input bit garbage, input int abortAt);
        logic [N-1:0] q0;
        logic [N:0]   bl, br;
        int           ac;
        bit           single;
        bl = '0;
        br = '0;
        @(negedge clk);
        start = 1'b1;
        mode  = m;
        amt   = AW'(a);
        d     = data;
        sin_l = fixSin ? fl : 1'($urandom);
        sin_r = fixSin ? fr : 1'($urandom);
        q0    = modelQ;
        ac    = (a > N) ? N : a;
`ifdef USR_BARREL_EN
        single = 1'b1;
        for (int j = 1; j <= N; j++) begin
            bl[j] = sin_l;
            br[j] = sin_r;
        end
`else
        single = (m == HOLD || m == LOAD || m == CLR || ac == 0);
`endif
        @(posedge clk);
        #1;
        if (single) begin
            if (m == LOAD) modelQ = data;
            else if (m == CLR) modelQ = '0;
            else if (m != HOLD && ac > 0) begin
                modelQ = refShift(m, q0, ac, bl, br);
                if (m == SHL || m == ROTL) modelSoL = q0[N-ac];
                else modelSoR = q0[ac-1];
            end
            checkAll("accept1", 1'b1, 1'b1);
        end else begin
            checkAll("accept", 1'b1, 1'b0);
            for (int i = 1; i <= ac; i++) begin
                @(negedge clk);
                if (fixSin) begin
                    sin_l = fl;
                    sin_r = fr;
                end else begin
                    sin_l = 1'($urandom);
                    sin_r = 1'($urandom);
                end
                bl[i] = sin_l;
                br[i] = sin_r;
                driveGarbage(garbage);
                if (abortAt == i) begin
                    start = 1'b0;
                    #2 reset = 1'b1;
                    #1;
                    modelQ   = '0;
                    modelSoL = 1'b0;
                    modelSoR = 1'b0;
                    checkAll("abort", 1'b0, 1'b0);
                    @(posedge clk);
                    #1 reset = 1'b0;
                    return;
                end
                @(posedge clk);
                #1;
                modelQ = refShift(m, q0, i, bl, br);
                if (m == SHL || m == ROTL) modelSoL = q0[N-i];
                else modelSoR = q0[i-1];
                checkAll("step", 1'b1, (i == ac));
            end
        end
        @(negedge clk);
        driveGarbage(garbage);
        @(posedge clk);
        #1;
        start = 1'b0;
        checkAll("idle", 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        mode  = HOLD;
        amt   = '0;
        d     = '0;
        sin_l = 1'b0;
        sin_r = 1'b0;
        modelQ   = '0;
        modelSoL = 1'b0;
        modelSoR = 1'b0;
        #12;
        checkAll("por", 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] asynchronous reset mid-cycle");
        applyStimulus(LOAD, 0, 8'hC3, 0, 0, 0, 0, 0);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        modelQ = '0;
        checkAll("async_rst", 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] directed sequences");
        applyStimulus(LOAD, 0, 8'hA5, 0, 0, 0, 0, 0);
        checkOutput("load_a5", 32'(q), 32'h A5);
        applyStimulus(SHL, 3, 8'h00, 1, 0, 1, 0, 0);
        checkOutput("shl3_q", 32'(q), 32'h2F);
        checkOutput("shl3_sol", 32'(so_l), 32'h1);
        applyStimulus(LOAD, 0, 8'h90, 0, 0, 0, 0, 0);
        applyStimulus(ASHR, 2, 8'h00, 0, 0, 0, 0, 0);
        checkOutput("ashr2_q", 32'(q), 32'hE4);
        checkOutput("ashr2_sor", 32'(so_r), 32'h0);
        applyStimulus(LOAD, 0, 8'h3C, 0, 0, 0, 0, 0);
        applyStimulus(ROTR, 15, 8'h00, 0, 0, 0, 0, 0);
        checkOutput("rotr15_q", 32'(q), 32'h3C);
        applyStimulus(LOAD, 0, 8'h5A, 0, 0, 0, 0, 0);
        applyStimulus(SHL, 4, 8'h00, 1, 0, 0, 1, 0);
        checkOutput("busy_ignore_q", 32'(q), 32'hA0);
        applyStimulus(LOAD, 0, 8'h77, 0, 0, 0, 0, 0);
        applyStimulus(SHL, 5, 8'h00, 1, 0, 1, 0, 2);
`ifndef USR_BARREL_EN
        checkOutput("abort_q", 32'(q), 32'h00);
`endif
        applyStimulus(LOAD, 0, 8'h11, 0, 0, 0, 0, 0);
        checkOutput("reload_q", 32'(q), 32'h11);
        applyStimulus(CLR, 6, 8'hFF, 0, 0, 0, 0, 0);
        checkOutput("clr_q", 32'(q), 32'h00);

        $display("[TB] random commands");
        for (int n = 0; n < 80; n++) begin
            applyStimulus(3'($urandom), $urandom_range(0, 15), N'($urandom),
                          1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 3) == 0), 0);
        end

        $display("[TB] == %0d vectors applied, %0d miscompares ==", numChecks, numErrors);
        $finish;
    end

endmodule
